// File: rtl/front_panel_pkg.sv
// Shared constants, direction/FSM encodings and input-decoding helpers for front_panel_cursor.
package front_panel_pkg;

  localparam int ROW0_COUNT        = 32'sd16;
  localparam int ROW1_COUNT        = 32'sd9;
  localparam int ROW1_BASE         = 32'sd16;
  localparam int SWITCH_COUNT      = ROW0_COUNT + ROW1_COUNT;
  localparam int REPEAT_DELAY      = 32'sd20;
  localparam int REPEAT_RATE       = 32'sd6;
  localparam int ACTION_MIN_FRAMES = 32'sd2;

  // Bit positions of the joystick inputs inside the synchronizer bus
  localparam int JOY_W     = 32'sd5;
  localparam int JOY_UP    = 32'sd0;
  localparam int JOY_DOWN  = 32'sd1;
  localparam int JOY_LEFT  = 32'sd2;
  localparam int JOY_RIGHT = 32'sd3;
  localparam int JOY_FIRE  = 32'sd4;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  function automatic dir_e pick_dir(input logic [3:0] rise);
    dir_e d;
    if (rise[JOY_UP]) begin
      d = DIR_UP;
    end else if (rise[JOY_DOWN]) begin
      d = DIR_DOWN;
    end else if (rise[JOY_LEFT]) begin
      d = DIR_LEFT;
    end else if (rise[JOY_RIGHT]) begin
      d = DIR_RIGHT;
    end else begin
      d = DIR_NONE;
    end
    return d;
  endfunction

  function automatic logic dir_level(input dir_e dir, input logic [3:0] lvl);
    logic held;
    case (dir)
      DIR_UP:    held = lvl[JOY_UP];
      DIR_DOWN:  held = lvl[JOY_DOWN];
      DIR_LEFT:  held = lvl[JOY_LEFT];
      DIR_RIGHT: held = lvl[JOY_RIGHT];
      default:   held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/front_panel_cursor_sync.sv
// Two-flop synchronizer with rising-edge detect; edges are suppressed until the
// pipeline has refilled after reset, so a button held through reset is not a press.
module front_panel_cursor_sync #(
  parameter int WIDTH = 32'sd5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       fill_q, fill_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    fill_d = {fill_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      fill_q <= 3'd0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  always_comb begin
    level_out = sync_q;
    if (fill_q[2]) begin
      rise_out = sync_q & ~prev_q;
    end else begin
      rise_out = '0;
    end
  end

endmodule

// File: rtl/front_panel_cursor.sv
// Front panel switch cursor: position, row wrap/clamp, action stretching.
// Define FRONT_PANEL_CURSOR_AUTOREPEAT_EN for frame-paced auto-repeat of held directions.
module front_panel_cursor #(
  parameter int ROW0_COUNT        = front_panel_pkg::ROW0_COUNT,
  parameter int ROW1_COUNT        = front_panel_pkg::ROW1_COUNT,
  parameter int ROW1_BASE         = front_panel_pkg::ROW1_BASE,
  parameter int REPEAT_DELAY      = front_panel_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE       = front_panel_pkg::REPEAT_RATE,
  parameter int ACTION_MIN_FRAMES = front_panel_pkg::ACTION_MIN_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic       joy_fire,
  output logic [3:0] cursor_index_x,
  output logic [4:0] cursor_index_y,
  output logic       cursor_action
);

  import front_panel_pkg::*;

  localparam logic [3:0] X0_MAX = 4'(ROW0_COUNT - 32'sd1);
  localparam logic [3:0] X1_MAX = 4'(ROW1_COUNT - 32'sd1);
  localparam logic [4:0] Y_ROW1 = 5'(ROW1_BASE);
  localparam int ACT_W = (ACTION_MIN_FRAMES < 32'sd1) ? 32'sd1 : $clog2(ACTION_MIN_FRAMES + 32'sd1);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACTION_MIN_FRAMES);

`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
  localparam int FRAME_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int FRAME_W   = (FRAME_MAX < 32'sd1) ? 32'sd1 : $clog2(FRAME_MAX + 32'sd1);
  localparam logic [FRAME_W-1:0] DELAY_LOAD = FRAME_W'(REPEAT_DELAY);
  localparam logic [FRAME_W-1:0] RATE_LOAD  = FRAME_W'(REPEAT_RATE);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(32'd1);
  logic [FRAME_W-1:0] frame_q, frame_d;
`endif

  logic [JOY_W-1:0] joy_level;
  logic [JOY_W-1:0] joy_rise;
  dir_e             edge_dir;
  dir_e             move_dir;
  logic             latch_held;
  logic             in_row1;
  logic [3:0]       row_max;

  state_e           state_q, state_d;
  dir_e             latch_q, latch_d;
  logic [3:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic             action_q, action_d;
  logic [ACT_W-1:0] act_cnt_q, act_cnt_d;

  front_panel_cursor_sync #(
    .WIDTH(JOY_W)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in ({joy_fire, joy_right, joy_left, joy_down, joy_up}),
    .level_out(joy_level),
    .rise_out (joy_rise)
  );

  always_comb begin
    edge_dir   = pick_dir(joy_rise[3:0]);
    latch_held = dir_level(latch_q, joy_level[3:0]);
    in_row1    = (y_q == Y_ROW1);
    row_max    = in_row1 ? X1_MAX : X0_MAX;
  end

  // State register for the direction FSM, cursor position and action stretcher
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      latch_q   <= DIR_NONE;
      x_q       <= 4'd0;
      y_q       <= 5'd0;
      action_q  <= 1'b0;
      act_cnt_q <= '0;
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
      frame_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      x_q       <= x_d;
      y_q       <= y_d;
      action_q  <= action_d;
      act_cnt_q <= act_cnt_d;
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
      frame_q   <= frame_d;
`endif
    end
  end

  // Next state: an active action freezes the cursor; a fresh edge always restarts the press
  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    move_dir = DIR_NONE;
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
    frame_d  = frame_q;
`endif
    if (action_q) begin
      state_d = ST_IDLE;
      latch_d = DIR_NONE;
    end else if (edge_dir != DIR_NONE) begin
      move_dir = edge_dir;
      latch_d  = edge_dir;
      state_d  = ST_HOLD;
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
      frame_d  = DELAY_LOAD;
`endif
    end else if (!latch_held) begin
      state_d = ST_IDLE;
      latch_d = DIR_NONE;
    end else begin
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
      if (frame_tick) begin
        if (frame_q <= FRAME_ONE) begin
          move_dir = latch_q;
          frame_d  = RATE_LOAD;
          state_d  = ST_REPEAT;
        end else begin
          frame_d  = frame_q - FRAME_ONE;
        end
      end else begin
        frame_d = frame_q;
      end
`else
      state_d = state_q;
`endif
    end
  end

  // Position update for the selected move; entering row 1 clamps x to that row
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (move_dir)
      DIR_UP: begin
        if (in_row1) begin
          y_d = 5'd0;
        end else begin
          y_d = y_q;
        end
      end
      DIR_DOWN: begin
        if (!in_row1) begin
          y_d = Y_ROW1;
          x_d = (x_q > X1_MAX) ? X1_MAX : x_q;
        end else begin
          y_d = y_q;
        end
      end
      DIR_LEFT:  x_d = (x_q == 4'd0) ? row_max : (x_q - 4'd1);
      DIR_RIGHT: x_d = (x_q >= row_max) ? 4'd0 : (x_q + 4'd1);
      default: begin
        x_d = x_q;
        y_d = y_q;
      end
    endcase
  end

  always_comb begin
    act_cnt_d = act_cnt_q;
    action_d  = action_q;
    if (joy_rise[JOY_FIRE]) begin
      action_d  = 1'b1;
      act_cnt_d = ACT_LOAD;
    end else begin
      if (frame_tick && (act_cnt_q != '0)) begin
        act_cnt_d = act_cnt_q - ACT_W'(32'd1);
      end else begin
        act_cnt_d = act_cnt_q;
      end
      if ((act_cnt_d == '0) && !joy_level[JOY_FIRE]) begin
        action_d = 1'b0;
      end else begin
        action_d = action_q;
      end
    end
  end

  assign cursor_index_x = x_q;
  assign cursor_index_y = y_q;
  assign cursor_action  = action_q;

endmodule

// File: tb/tb_front_panel_cursor.sv
// Scoreboard bench for front_panel_cursor: a behavioural model predicts outputs per clock.
module tb_front_panel_cursor;

  localparam int X0_MAX = 15;
  localparam int X1_MAX = 8;
  localparam int Y1     = 16;
  localparam int DELAY  = 20;
  localparam int RATE   = 6;
  localparam int AMIN   = 2;
`ifdef FRONT_PANEL_CURSOR_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       joy_up = 1'b0, joy_down = 1'b0, joy_left = 1'b0, joy_right = 1'b0, joy_fire = 1'b0;
  logic [3:0] cursor_index_x;
  logic [4:0] cursor_index_y;
  logic       cursor_action;

  front_panel_cursor dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .joy_up        (joy_up),
    .joy_down      (joy_down),
    .joy_left      (joy_left),
    .joy_right     (joy_right),
    .joy_fire      (joy_fire),
    .cursor_index_x(cursor_index_x),
    .cursor_index_y(cursor_index_y),
    .cursor_action (cursor_action)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] x;
    logic [4:0] y;
    logic       a;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] raw_hist[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_edge = 0;
  bit random_ticks = 1'b0;

  // model state: column, row (0/1), action flag, frames of action left, held dir (0 none, 1..4 up/down/left/right), frames to next repeat
  int m_x = 0, m_row = 0, m_act = 0, m_acnt = 0, m_held = 0, m_frames = 0;

  task automatic do_move(input int d);
    int maxx;
    maxx = (m_row != 0) ? X1_MAX : X0_MAX;
    case (d)
      1: if (m_row != 0) m_row = 0;
      2: if (m_row == 0) begin
           m_row = 1;
           if (m_x > X1_MAX) m_x = X1_MAX;
         end
      3: m_x = (m_x == 0) ? maxx : m_x - 1;
      4: m_x = (m_x == maxx) ? 0 : m_x + 1;
      default: ;
    endcase
  endtask

  // raw value driven in call n is seen as a synced level at clock edge n+3
  task automatic model_step(input bit rst, input bit tick);
    logic [4:0] lvl, plvl, rise;
    int n, j, d;
    n = cyc;
    j = n + 1;
    lvl  = (n >= 2) ? raw_hist[n-2] : 5'b0;
    plvl = (n >= 3) ? raw_hist[n-3] : 5'b0;
    if (rst) begin
      m_x = 0; m_row = 0; m_act = 0; m_acnt = 0; m_held = 0; m_frames = 0;
      rst_edge = j;
    end else begin
      rise = (j >= rst_edge + 4) ? (lvl & ~plvl) : 5'b0;
      d = 0;
      for (int k = 3; k >= 0; k--) if (rise[k]) d = k + 1;
      if (m_act != 0) m_held = 0;
      else if (d != 0) begin
        do_move(d);
        m_held = d;
        m_frames = DELAY;
      end else if (m_held != 0 && !lvl[m_held-1]) m_held = 0;
      else if (m_held != 0 && AUTOREPEAT && tick) begin
        m_frames = m_frames - 1;
        if (m_frames <= 0) begin
          do_move(m_held);
          m_frames = RATE;
        end
      end
      if (rise[4]) begin
        m_act = 1;
        m_acnt = AMIN;
      end else begin
        if (tick && m_acnt > 0) m_acnt = m_acnt - 1;
        if (m_acnt == 0 && !lvl[4]) m_act = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [4:0] pat);
    bit tick;
    exp_t e;
    @(negedge clk);
    if (random_ticks) tick = ($urandom_range(0, 7) == 0);
    else tick = ((cyc % 100) == 99);
    reset = rst;
    frame_tick = tick;
    {joy_fire, joy_right, joy_left, joy_down, joy_up} = pat;
    raw_hist.push_back(pat);
    model_step(rst, tick);
    e.x = 4'(m_x);
    e.y = 5'((m_row != 0) ? Y1 : 0);
    e.a = 1'(m_act);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic press(input logic [4:0] pat, input int hold, input int rel);
    repeat (hold) step(1'b0, pat);
    repeat (rel) step(1'b0, 5'b0);
  endtask

  task automatic check_const(input string name, input int x, input int y, input int a);
    checks++;
    if (cursor_index_x !== 4'(x) || cursor_index_y !== 5'(y) || cursor_action !== 1'(a)) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d act=%0d, expected x=%0d y=%0d act=%0d",
               name, cursor_index_x, cursor_index_y, cursor_action, x, y, a);
    end
  endtask

  // monitor: each clock edge consumes one predicted output
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cursor_index_x !== e.x || cursor_index_y !== e.y || cursor_action !== e.a) begin
          errors++;
          $display("FAIL cursor @%0t: got x=%0d y=%0d act=%0d, expected x=%0d y=%0d act=%0d",
                   $time, cursor_index_x, cursor_index_y, cursor_action, e.x, e.y, e.a);
        end
      end
    end
  end

  initial begin
    repeat (4) step(1'b1, 5'b0);
    press(5'b0, 0, 8);
    check_const("reset", 0, 0, 0);

    repeat (3) press(5'b01000, 10, 10);
    check_const("right_x3", 3, 0, 0);
    repeat (12) press(5'b01000, 10, 10);
    check_const("right_to_15", 15, 0, 0);
    press(5'b01000, 10, 10);
    check_const("wrap_right_row0", 0, 0, 0);
    press(5'b00100, 10, 10);
    check_const("wrap_left_row0", 15, 0, 0);
    repeat (3) press(5'b00100, 10, 10);
    press(5'b00010, 10, 10);
    check_const("down_clamp", 8, 16, 0);
    press(5'b00010, 10, 10);
    check_const("down_ignored", 8, 16, 0);
    press(5'b01000, 10, 10);
    check_const("wrap_right_row1", 0, 16, 0);
    press(5'b00100, 10, 10);
    check_const("wrap_left_row1", 8, 16, 0);
    press(5'b01001, 10, 10);
    check_const("up_over_right", 8, 0, 0);

    press(5'b10000, 2, 0);
    press(5'b11000, 3, 0);
    press(5'b01000, 5, 0);
    check_const("action_on", 8, 0, 1);
    press(5'b0, 0, 250);
    check_const("action_done", 8, 0, 0);

    press(5'b00100, 2800, 0);
    press(5'b10100, 8, 0);
    repeat (2) step(1'b1, 5'b10100);
    press(5'b10100, 20, 0);
    check_const("reset_held", 0, 0, 0);
    press(5'b0, 0, 10);
    press(5'b00100, 10, 10);
    check_const("repress_left", 15, 0, 0);

    random_ticks = 1'b1;
    for (int ep = 0; ep < 120; ep++) begin
      logic [4:0] pat;
      pat = 5'b0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) pat[b] = 1'b1;
      if ($urandom_range(0, 5) == 0) pat[4] = 1'b1;
      if ($urandom_range(0, 29) == 0) repeat ($urandom_range(1, 3)) step(1'b1, pat);
      press(pat, $urandom_range(1, 200), $urandom_range(1, 30));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
